mdu: RTL and testbench
======================

# mdu

Multi-cycle multiply/divide unit paired with the single-cycle `alu` in the EX stage. It accepts an operation and two 32-bit operands on a one-cycle `Start` pulse and holds `Busy` for the operation's fixed latency. It then commits the result to internal HI/LO registers. It also executes `mthi`/`mtlo` writes and continuously drives HI/LO for `mfhi`/`mflo`.

## Interface
- `MULT_CYCLES`, 5: cycles `Busy` is held for `mult`/`multu`.
- `DIV_CYCLES`, 10: cycles `Busy` is held for `div`/`divu`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `Start`  in  1  one-cycle request pulse; qualifies `MDUOp`, `A` and `B`.
- `MDUOp`  in  3  operation code: 000 `multu`, 001 `mult`, 010 `divu`, 011 `div`, 100 `mthi`, 101 `mtlo`; 110 and 111 are reserved.
- `A`  in  32  rs operand (dividend, multiplicand, or the `mthi`/`mtlo` source).
- `B`  in  32  rt operand (divisor or multiplier).
- `Busy`  out  1  registered; high while a mult/div is in flight.
- `HI`  out  32  registered HI register.
- `LO`  out  32  registered LO register.

## Operation
- State machine states:
  - IDLE: `Busy`=0; `Start` is accepted.
  - RUN: `Busy`=1; a down-counter counts the remaining cycles.
- IDLE with `Start`=1 and a mult/div op:
  - Latch `A`, `B` and `MDUOp` into internal operand registers.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- IDLE with `Start`=1 and `mthi`: HI <= `A` at this edge. LO is unchanged, `Busy` stays 0, and the state stays IDLE.
- IDLE with `Start`=1 and `mtlo`: LO <= `A` at this edge. HI is unchanged, `Busy` stays 0, and the state stays IDLE.
- IDLE with `Start`=1 and a reserved op (110, 111): no effect.
- RUN: the counter decrements by 1 each edge. On the edge where the counter goes from 1 to 0:
  - Write HI/LO from the latched operands.
  - Return to IDLE.
- Arithmetic, computed from the latched operands only; inputs changing during RUN have no effect:
  - `multu`: {HI,LO} = zero-extended 64-bit product.
  - `mult`: {HI,LO} = sign-extended 64-bit two's-complement product.
  - `divu`: LO = unsigned quotient; HI = unsigned remainder.
  - `div`: LO = quotient truncated toward zero; HI = remainder, which carries the sign of the dividend.
  - `div` overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
  - Divide by zero (`div` or `divu`): full `DIV_CYCLES` latency; HI and LO are left unchanged.
- `Start` while `Busy`=1 is ignored completely, including `mthi`/`mtlo`. The pipeline stall logic must hold the instruction and re-issue it after `Busy` falls.
- Stall rule for the pipeline: stall any MD instruction, `mfhi` or `mflo` in EX while `Start`|`Busy` is high for an in-flight mult/div.

## Timing
- Reset values: `Busy`=0, HI=0, LO=0, state IDLE, counter 0.
- `reset` takes priority over every other input. Asserting it during RUN aborts the operation: no HI/LO commit, and `Busy`=0 after that edge.
- Mult/div latency: `Start` sampled at edge t0.
  - `Busy`=1 from after t0 through the cycle before t0+N, where N is `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO take the new values, and `Busy`=0, after edge t0+N.
- Back-to-back issue: a new `Start` is accepted in the first cycle after `Busy` falls, i.e. it is sampled at edge t0+N+1. No dead cycle is required.
- `mthi`/`mtlo` latency: one edge. HI/LO are readable in the next cycle, and `Busy` never rises.
- `Busy` is a registered output. It does not rise in the same cycle as `Start`.

## Test plan
- Signed and unsigned multiply of the same operands.
  - Stimulus: reset, then `mult` with A=0xFFFFFFFE (-2), B=3.
  - Required: `Busy`=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Stimulus: repeat as `multu` with the same operands.
  - Required: HI=0x00000002, LO=0xFFFFFFFA.
- Signed divide and divide overflow.
  - Stimulus: `div` with A=0xFFFFFFF9 (-7), B=2.
  - Required: `Busy` for exactly 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Stimulus: `div` with A=0x80000000, B=0xFFFFFFFF.
  - Required: LO=0x80000000, HI=0.
- Divide by zero.
  - Stimulus: `mthi` A=0x11, `mtlo` A=0x22, then `divu` with B=0.
  - Required: after 10 `Busy` cycles, HI=0x11 and LO=0x22 are unchanged.
- Start ignored while busy.
  - Stimulus: `multu` 7×6; during the 3rd `Busy` cycle pulse `Start` with `mtlo` A=0xDEAD and change `A`/`B`.
  - Required: LO=42, HI=0; the `mtlo` has no effect.
- Reset mid-operation.
  - Stimulus: `divu` 100/7; assert `reset` during the 4th `Busy` cycle.
  - Required: after that edge, `Busy`=0, HI=0, LO=0, and no later commit occurs.
  - Stimulus: a fresh `multu` 2×3 issued next cycle.
  - Required: LO=6 after 5 cycles.
- Back-to-back issue.
  - Stimulus: `mult` 0x7FFFFFFF×2; issue `divu` 9/4 in the first cycle after `Busy` falls.
  - Required: HI=0, LO=0xFFFFFFFE after the mult.
  - Required: `divu` accepted immediately, and after it HI=1, LO=2.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and single-edge mthi/mtlo writes.
// Latency: MULT_CYCLES or DIV_CYCLES edges after Start. Start is ignored while Busy is high.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d;

  logic          done;
  logic [63:0]   prod_u, prod_s;
  logic [31:0]   b_safe, quot_u, rem_u;
  logic signed [31:0] quot_s, rem_s;
  logic          div_ovf;

  assign done = (state_q == RUN) && (cnt_q == CW'(1));

  // Divisor is forced nonzero so the divider never sees 0; zero-divisor commits are suppressed below.
  assign b_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
  assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
  assign prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign quot_u  = a_q / b_safe;
  assign rem_u   = a_q % b_safe;
  assign quot_s  = $signed(a_q) / $signed(b_safe);
  assign rem_s   = $signed(a_q) % $signed(b_safe);
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (Start && (MDUOp[2] == 1'b0)) begin
          state_d = RUN;
          cnt_d   = MDUOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          op_d    = MDUOp;
          a_d     = A;
          b_d     = B;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = (state_d == RUN);
    if ((state_q == IDLE) && Start) begin
      if (MDUOp == OP_MTHI) hi_d = A;
      if (MDUOp == OP_MTLO) lo_d = A;
    end
    if (done) begin
      case (op_q)
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_DIVU: begin
          if (b_q != 32'd0) begin
            hi_d = rem_u;
            lo_d = quot_u;
          end
        end
        OP_DIV: begin
          if (div_ovf) begin
            hi_d = 32'd0;
            lo_d = 32'h8000_0000;
          end else if (b_q != 32'd0) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed vector bench for mdu: table of ops with expected HI/LO and Busy length,
// plus hand-written sequences for Start-while-busy and reset abort.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_hi = hi; v.exp_lo = lo; v.exp_cyc = cyc;
    vecs.push_back(v);
  endtask

  // Called at a negedge with Start already driven low; counts Busy cycles until it falls.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Drives a one-cycle Start at the current negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDUOp = op;
    A     = a;
    B     = b;
    #1;
    check("busy_low_with_start", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    Start  = 1'b0;
    MDUOp  = 3'b000;
    A      = 32'd0;
    B      = 32'd0;

    add(3'b001, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    add(3'b000, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5);
    add(3'b011, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    add(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    add(3'b011, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    add(3'b001, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C, 5);
    add(3'b010, 32'd100,       32'd7,        32'd2,          32'd14,         10);
    add(3'b100, 32'h11,        32'h55,       32'h11,         32'd14,         0);
    add(3'b101, 32'h22,        32'h55,       32'h11,         32'h22,         0);
    add(3'b010, 32'd5,         32'd0,        32'h11,         32'h22,         10);
    add(3'b011, 32'd5,         32'd0,        32'h11,         32'h22,         10);
    add(3'b110, 32'hFFFF,      32'hFFFF,     32'h11,         32'h22,         0);
    add(3'b111, 32'hFFFF,      32'hFFFF,     32'h11,         32'h22,         0);
    add(3'b001, 32'h7FFF_FFFF, 32'd2,        32'h0000_0000, 32'hFFFF_FFFE, 5);
    add(3'b010, 32'd9,         32'd4,        32'd1,          32'd2,          10);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    // Each vector is issued at the negedge where the previous one went idle: back-to-back issue.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(cyc);
      check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
    end

    // mtlo pulsed during the 3rd Busy cycle of a multu must be ignored.
    issue(3'b000, 32'd7, 32'd6);
    @(negedge clk);
    @(negedge clk);
    Start = 1'b1;
    MDUOp = 3'b101;
    A     = 32'hDEAD;
    B     = 32'hBEEF;
    @(negedge clk);
    Start = 1'b0;
    wait_idle(cyc);
    check("ignore_busy_cycles", 32'(cyc + 3), 32'd5);
    check("ignore_hi", HI, 32'd0);
    check("ignore_lo", LO, 32'd42);

    // Reset during the 4th Busy cycle of divu aborts it.
    issue(3'b010, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("abort_busy_before_reset", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    issue(3'b000, 32'd2, 32'd3);
    wait_idle(cyc);
    check("post_reset_busy_cycles", 32'(cyc), 32'd5);
    check("post_reset_hi", HI, 32'd0);
    check("post_reset_lo", LO, 32'd6);
    repeat (8) @(negedge clk);
    check("no_late_commit_busy", {31'd0, Busy}, 32'd0);
    check("no_late_commit_hi", HI, 32'd0);
    check("no_late_commit_lo", LO, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
